ibex_xif_csr_shadow_wr_ctrl: RTL and testbench
==============================================

// Module: ibex_xif_csr_shadow_wr_ctrl
//
// PURPOSE
//   Write-side controller for a shadowed CSR storage primitive.
//   Implements a two-phase write protocol: the first request stages a value; a
//   second, identical request commits it to the CSR.
//   Computes read-modify-write results, drives the CSR write port, and read-back
//   verifies the stored value after each commit.
//   Continuously monitors the CSR shadow-mismatch error line.
//   Sits between the CSR access decode and one CSR storage instance.
//
// PARAMETERS
//   Width          32    CSR data width in bits
//   WriteMask      '1    [Width-1:0]; bits writable by software; clear bits keep current value
//   TimeoutCycles  16    cycles a staged value waits for its commit request; legal range >=2
//
// PORTS
//   clk_i            in   1      clock
//   rst_ni           in   1      asynchronous reset, active low
//   req_i            in   1      software write request, valid for one cycle
//   req_op_i         in   2      2'b00 write, 2'b01 set bits, 2'b10 clear bits, 2'b11 reserved (= write)
//   req_data_i       in   Width  request operand
//   ready_o          out  1      controller accepts req_i this cycle
//   csr_rd_data_i    in   Width  current CSR contents
//   csr_rd_error_i   in   1      CSR shadow mismatch indication
//   csr_wr_data_o    out  Width  CSR write data
//   csr_wr_en_o      out  1      CSR write enable
//   staged_o         out  1      a value is staged and awaiting commit
//   done_o           out  1      pulse: commit written and read-back verified
//   update_err_o     out  1      pulse: commit value differs from staged value; nothing written
//   timeout_o        out  1      pulse: staged value discarded after TimeoutCycles
//   storage_err_o    out  1      sticky: CSR read-back mismatch or csr_rd_error_i seen
//
// BEHAVIOUR
//   Reset values
//   - Every output is 0 at reset.
//   - csr_wr_data_o and the stage register reset to '0; the timer resets to 0.
//   - Reset mid-operation returns the FSM to IDLE and discards any staged value;
//     no write is issued.
//   Value computation
//   - new = (op_result & WriteMask) | (csr_rd_data_i & ~WriteMask).
//   - op_result: write = req_data_i; set = csr_rd_data_i | req_data_i;
//     clear = csr_rd_data_i & ~req_data_i.
//   - new is evaluated in the cycle the request is accepted.
//   FSM states: IDLE, STAGED, COMMIT, VERIFY
//   - ready_o = 1 in IDLE and STAGED only; req_i in COMMIT or VERIFY is ignored.
//   - IDLE, req_i: stage_q <= new, timer <= 0, go to STAGED.
//   - STAGED: staged_o = 1; the timer increments every cycle without req_i.
//   - STAGED, req_i and new == stage_q: go to COMMIT.
//   - STAGED, req_i and new != stage_q: update_err_o pulses for 1 cycle in the
//     following cycle, go to IDLE; no CSR write.
//   - STAGED, no req_i, timer == TimeoutCycles-1: timeout_o pulses for 1 cycle
//     in the following cycle, go to IDLE.
//     If req_i arrives in that same cycle, req_i wins and no timeout occurs.
//   - COMMIT (1 cycle): csr_wr_en_o = 1 and csr_wr_data_o = stage_q; go to VERIFY.
//   - VERIFY (1 cycle): compare csr_rd_data_i with stage_q.
//     Mismatch sets storage_err_o. done_o = 1 either way; go to IDLE.
//   Latency
//   - Commit request at cycle N gives csr_wr_en_o at N+1 and done_o at N+2.
//   - ready_o returns to 1 at N+3.
//   Error monitoring
//   - csr_rd_error_i = 1 in any state sets storage_err_o.
//   - storage_err_o clears only on reset.
//   csr_wr_en_o is never asserted outside COMMIT.
//
// TESTING
//   - Write 0xA5A5_0001 twice back-to-back: staged_o=1 after the first;
//     csr_wr_en_o at N+1 with data 0xA5A5_0001; done_o at N+2; storage_err_o=0.
//   - Stage 0x1234, then request 0x1235: update_err_o pulse, no csr_wr_en_o,
//     CSR value unchanged, FSM back in IDLE.
//   - Stage a value and send no further request for 16 cycles:
//     timeout_o pulses once, staged_o=0, no write.
//     Repeat with the commit request on the timeout cycle: commit occurs and
//     timeout_o stays 0.
//   - CSR = 0x00F0, WriteMask = 0x00FF: set 0x0F0F twice -> written 0x00FF;
//     clear 0x00F0 twice -> written 0x000F.
//   - Force csr_rd_data_i to 0xDEAD during VERIFY after a commit of 0xBEEF:
//     storage_err_o = 1 and stays set.
//     Separately, assert csr_rd_error_i for 1 cycle in IDLE: storage_err_o = 1.
//   - Assert rst_ni low while in STAGED: all outputs 0.
//     A single request after reset only stages; no write is issued.

Source files
------------

// File: rtl/ibex_xif_csr_shadow_wr_ctrl_if.sv
// ibex_xif_csr_shadow_wr_ctrl_if: request, CSR-port and status signals of the shadow CSR write controller
//   slave  : controller side (receives requests and CSR read data, drives the CSR write port and status)
//   master : environment side (issues requests, models the CSR storage instance)
//   req_i/req_op_i/req_data_i/ready_o           software write request handshake
//   csr_rd_data_i/csr_rd_error_i                 CSR read-back and shadow mismatch line
//   csr_wr_data_o/csr_wr_en_o                    CSR write port
//   staged_o/done_o/update_err_o/timeout_o/storage_err_o  status
interface ibex_xif_csr_shadow_wr_ctrl_if #(
    parameter int unsigned Width = 32
);
    logic             req_i;
    logic [1:0]       req_op_i;
    logic [Width-1:0] req_data_i;
    logic             ready_o;
    logic [Width-1:0] csr_rd_data_i;
    logic             csr_rd_error_i;
    logic [Width-1:0] csr_wr_data_o;
    logic             csr_wr_en_o;
    logic             staged_o;
    logic             done_o;
    logic             update_err_o;
    logic             timeout_o;
    logic             storage_err_o;

    modport slave (
        input  req_i, req_op_i, req_data_i, csr_rd_data_i, csr_rd_error_i,
        output ready_o, csr_wr_data_o, csr_wr_en_o, staged_o, done_o,
               update_err_o, timeout_o, storage_err_o
    );

    modport master (
        output req_i, req_op_i, req_data_i, csr_rd_data_i, csr_rd_error_i,
        input  ready_o, csr_wr_data_o, csr_wr_en_o, staged_o, done_o,
               update_err_o, timeout_o, storage_err_o
    );
endinterface

// File: rtl/ibex_xif_csr_shadow_wr_ctrl.sv
// ibex_xif_csr_shadow_wr_ctrl: two-phase (stage, then identical commit) write controller for a shadowed CSR
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : request handshake, CSR read/write port, status pulses and sticky storage error
//   A first request stages the masked read-modify-write result; a second request yielding the
//   same value commits it (one write cycle), after which the CSR is read back and checked.
module ibex_xif_csr_shadow_wr_ctrl #(
    parameter int unsigned      Width         = 32,
    parameter logic [Width-1:0] WriteMask     = '1,
    parameter int unsigned      TimeoutCycles = 16
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    ibex_xif_csr_shadow_wr_ctrl_if.slave bus
);
    localparam int unsigned TimerW = $clog2(TimeoutCycles);
    localparam logic [1:0] Idle   = 2'd0;
    localparam logic [1:0] Staged = 2'd1;
    localparam logic [1:0] Commit = 2'd2;
    localparam logic [1:0] Verify = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [Width-1:0]  stage_q, wr_data_q, op_result, new_val, rd;
    logic [TimerW-1:0] timer_q;
    logic              ready_q, update_err_q, timeout_q, storage_err_q;
    logic              accept, match, expire;
    assign rd        = bus.csr_rd_data_i;
    assign op_result = bus.req_op_i == 2'b01 ? rd | bus.req_data_i :
                       bus.req_op_i == 2'b10 ? rd & ~bus.req_data_i : bus.req_data_i;
    assign new_val   = (op_result & WriteMask) | (rd & ~WriteMask);
    assign accept    = bus.req_i && (state_q == Idle || state_q == Staged);
    assign match     = new_val == stage_q;
    // A request in the last waiting cycle takes priority over the timeout.
    assign expire    = state_q == Staged && !bus.req_i && timer_q == TimerW'(TimeoutCycles - 1);
    assign state_d   = state_q == Commit ? Verify :
                       state_q == Verify ? Idle :
                       state_q == Idle   ? (accept ? Staged : Idle) :
                       accept            ? (match ? Commit : Idle) :
                       expire            ? Idle : Staged;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            stage_q       <= '0;
            wr_data_q     <= '0;
            timer_q       <= '0;
            ready_q       <= 1'b0;
            update_err_q  <= 1'b0;
            timeout_q     <= 1'b0;
            storage_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            // Registered so ready_o is low while in reset and tracks the next state exactly.
            ready_q       <= state_d == Idle || state_d == Staged;
            update_err_q  <= accept && state_q == Staged && !match;
            timeout_q     <= expire;
            storage_err_q <= storage_err_q || bus.csr_rd_error_i || (state_q == Verify && rd != stage_q);
            timer_q       <= state_q == Staged ? timer_q + 1'b1 : '0;
            if (accept && state_q == Idle) stage_q <= new_val;
            if (state_d == Commit) wr_data_q <= stage_q;
        end
    end
    assign bus.ready_o       = ready_q;
    assign bus.staged_o      = state_q == Staged;
    assign bus.csr_wr_en_o   = state_q == Commit;
    assign bus.csr_wr_data_o = wr_data_q;
    assign bus.done_o        = state_q == Verify;
    assign bus.update_err_o  = update_err_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.storage_err_o = storage_err_q;
endmodule

// File: tb/tb_ibex_xif_csr_shadow_wr_ctrl.sv
// tb_ibex_xif_csr_shadow_wr_ctrl: scoreboard bench; stimulus queues expected CSR events, a monitor pops and checks them
module tb_ibex_xif_csr_shadow_wr_ctrl;
    localparam logic [31:0] Mask = 32'hFFFF_00FF;
    localparam logic [3:0] WR = 4'b1000;
    localparam logic [3:0] DN = 4'b0100;
    localparam logic [3:0] UE = 4'b0010;
    localparam logic [3:0] TO = 4'b0001;

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
        int          cyc;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] csr_q = '0;
    logic [31:0] preload_val = '0;
    logic        preload = 1'b0;
    logic        override = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    evt_t        exp_q[$];

    always #5 clk = ~clk;

    ibex_xif_csr_shadow_wr_ctrl_if #(.Width(32)) bus ();

    ibex_xif_csr_shadow_wr_ctrl #(
        .Width(32),
        .WriteMask(Mask),
        .TimeoutCycles(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // CSR storage model: written by the DUT, or preloaded by the bench between tests.
    always @(posedge clk) begin
        if (preload) csr_q <= preload_val;
        else if (bus.csr_wr_en_o) csr_q <= bus.csr_wr_data_o;
    end
    assign bus.csr_rd_data_i = override ? 32'h0000_DEAD : csr_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] kind, input logic [31:0] data, input int c);
        evt_t e;
        e.kind = kind;
        e.data = data;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d, output int c);
        bus.req_i = 1'b1;
        bus.req_op_i = op;
        bus.req_data_i = d;
        c = cyc;
        tick();
        bus.req_i = 1'b0;
    endtask

    task automatic commit(input logic [1:0] op, input logic [31:0] d, input logic [31:0] exp_wr);
        int c1, c2;
        send(op, d, c1);
        send(op, d, c2);
        push(WR, exp_wr, c2 + 1);
        push(DN, '0, c2 + 2);
        wait_to(c2 + 3);
        chk("csr_after_commit", csr_q, exp_wr);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_flags"}, {25'd0, bus.ready_o, bus.staged_o, bus.csr_wr_en_o, bus.done_o,
                               bus.update_err_o, bus.timeout_o, bus.storage_err_o}, '0);
        chk({name, "_wr_data"}, bus.csr_wr_data_o, '0);
    endtask

    always @(negedge clk) begin
        logic [3:0] k;
        evt_t e;
        k = {bus.csr_wr_en_o, bus.done_o, bus.update_err_o, bus.timeout_o};
        if (k != 4'b0) begin
            if (exp_q.size() == 0) chk("unexpected_event", 32'(k), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                chk("event_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == WR) chk("wr_data", bus.csr_wr_data_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c, c2;
        bus.req_i = 1'b0;
        bus.req_op_i = 2'b00;
        bus.req_data_i = '0;
        bus.csr_rd_error_i = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.ready_o), 32'd1);

        // Back-to-back identical writes: stage, then commit with N+1/N+2/N+3 latency.
        send(2'b00, 32'hA5A5_0001, c);
        chk("staged_after_first", 32'(bus.staged_o), 32'd1);
        send(2'b00, 32'hA5A5_0001, c2);
        push(WR, 32'hA5A5_0001, c2 + 1);
        push(DN, '0, c2 + 2);
        chk("ready_in_commit", 32'(bus.ready_o), 32'd0);
        wait_to(c2 + 2);
        chk("ready_in_verify", 32'(bus.ready_o), 32'd0);
        wait_to(c2 + 3);
        chk("ready_after_done", 32'(bus.ready_o), 32'd1);
        chk("storage_err_clean", 32'(bus.storage_err_o), 32'd0);
        chk("csr_a5a5", csr_q, 32'hA5A5_0001);

        // Differing commit value: update error, no write.
        send(2'b00, 32'h0000_1234, c);
        send(2'b00, 32'h0000_1235, c2);
        push(UE, '0, c2 + 1);
        wait_to(c2 + 2);
        chk("staged_after_upd_err", 32'(bus.staged_o), 32'd0);
        chk("ready_after_upd_err", 32'(bus.ready_o), 32'd1);
        chk("csr_unchanged_upd_err", csr_q, 32'hA5A5_0001);

        // Timeout after 16 waiting cycles.
        send(2'b00, 32'h0000_0055, c);
        push(TO, '0, c + 17);
        wait_to(c + 16);
        chk("staged_before_timeout", 32'(bus.staged_o), 32'd1);
        wait_to(c + 18);
        chk("staged_after_timeout", 32'(bus.staged_o), 32'd0);
        chk("csr_unchanged_timeout", csr_q, 32'hA5A5_0001);

        // Commit on the timeout cycle wins.
        send(2'b00, 32'h0000_0055, c);
        wait_to(c + 16);
        send(2'b00, 32'h0000_0055, c2);
        push(WR, 32'h0000_0055, c2 + 1);
        push(DN, '0, c2 + 2);
        wait_to(c2 + 3);
        chk("csr_commit_on_timeout_cycle", csr_q, 32'h0000_0055);

        // Set/clear under the write mask; masked bits 15:8 keep the CSR contents.
        preload_val = 32'h0000_00F0; preload = 1'b1; tick(); preload = 1'b0;
        commit(2'b01, 32'h0000_0F0F, 32'h0000_00FF);
        commit(2'b10, 32'h0000_00F0, 32'h0000_000F);
        preload_val = 32'h0000_AB00; preload = 1'b1; tick(); preload = 1'b0;
        commit(2'b00, 32'h1234_5678, 32'h1234_AB78);
        commit(2'b11, 32'hCAFE_00FF, 32'hCAFE_ABFF);

        // Read-back mismatch during verify sets the sticky error.
        preload_val = 32'h0000_BE00; preload = 1'b1; tick(); preload = 1'b0;
        send(2'b00, 32'h0000_BEEF, c);
        send(2'b00, 32'h0000_BEEF, c2);
        push(WR, 32'h0000_BEEF, c2 + 1);
        push(DN, '0, c2 + 2);
        wait_to(c2 + 2);
        chk("storage_err_before_verify", 32'(bus.storage_err_o), 32'd0);
        override = 1'b1;
        tick();
        override = 1'b0;
        chk("storage_err_readback", 32'(bus.storage_err_o), 32'd1);
        tick(3);
        chk("storage_err_sticky", 32'(bus.storage_err_o), 32'd1);

        // Reset while staged clears everything; a single request afterwards only stages.
        send(2'b00, 32'h0000_0077, c);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_in_staged");
        tick(2);
        rst_n = 1'b1;
        tick();
        send(2'b00, 32'h0000_0099, c);
        push(TO, '0, c + 17);
        tick(5);
        chk("staged_after_reset_req", 32'(bus.staged_o), 32'd1);
        chk("csr_no_write_after_reset", csr_q, 32'h0000_BEEF);
        wait_to(c + 18);
        chk("staged_after_reset_timeout", 32'(bus.staged_o), 32'd0);

        // Shadow mismatch line in IDLE.
        chk("storage_err_cleared_by_reset", 32'(bus.storage_err_o), 32'd0);
        bus.csr_rd_error_i = 1'b1;
        tick();
        bus.csr_rd_error_i = 1'b0;
        chk("storage_err_rd_error", 32'(bus.storage_err_o), 32'd1);

        tick(2);
        chk("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
